decoder_pipe_param: RTL and testbench
=====================================

DECODER_PIPE_PARAM -- requirements
Module: decoder_pipe_param

Interface
REQ-001 SHALL have parameter SEL_W, default 4, meaning the select width in bits (legal range 2..8).
REQ-002 SHALL have parameter SUB_W, default 3, meaning the select bits per sub-decoder bank (legal range 1..SEL_W-1).
REQ-003 SHALL have parameter OUT_W, default 16, meaning the number of populated outputs (legal range 2..2**SEL_W).
REQ-004 SHALL have parameter CNT_W, default 16, meaning the width of the accepted-decode counter.
REQ-005 SHALL have one clock and a synchronous, active-low reset: clk  in  1  rising-edge clock, the only clock in the block.
REQ-006 SHALL have port rst_n  in  1  reset, synchronous to clk and active-low.
REQ-007 SHALL have port in_valid  in  1  request valid.
REQ-008 SHALL have port in_ready  out  1  request accepted when high together with in_valid.
REQ-009 SHALL have port in_sel  in  SEL_W  index to decode.
REQ-010 SHALL have port in_mode  in  2  decode mode: 00 one-hot, 01 thermometer, 10 one-cold, 11 reserved.
REQ-011 SHALL have port out_valid  out  1  decoded word valid.
REQ-012 SHALL have port out_ready  in  1  downstream accepts word.
REQ-013 SHALL have port out_word  out  OUT_W  decoded word.
REQ-014 SHALL have port out_err  out  1  set with the word when in_sel >= OUT_W or in_mode == 11.
REQ-015 SHALL have port dec_count  out  CNT_W  count of accepted requests, saturating.

Function
REQ-016 SHALL accept a request on a rising clk edge where in_valid && in_ready are both high.
REQ-017 SHALL be a two-stage pipeline: S1 registers in_sel, in_mode and the upper bits in_sel[SEL_W-1:SUB_W] decoded to a one-hot bank enable; S2 registers out_word and out_err.
REQ-018 SHALL raise out_valid exactly 2 cycles after acceptance when out_ready is held high.
REQ-019 SHALL sustain 1 word/cycle while out_ready is high.
REQ-020 SHALL compute s1_adv = !s2_valid || out_ready and drive in_ready = !s1_valid || s1_adv combinationally, with no combinational path from in_valid to in_ready.
REQ-021 SHALL hold out_word, out_err and out_valid stable while out_valid && !out_ready, and SHALL neither lose nor duplicate words under any stall pattern.
REQ-022 SHALL, in one-hot mode, set out_word[k] = (k == sel).
REQ-023 SHALL, in thermometer mode, set out_word[k] = (k <= sel).
REQ-024 SHALL, in one-cold mode, set out_word[k] = (k != sel).
REQ-025 SHALL, when sel >= OUT_W, drive out_word all zeros in every mode with out_err = 1.
REQ-026 SHALL, in reserved mode 11, drive out_word all zeros with out_err = 1.
REQ-027 SHALL increment dec_count by 1 on each acceptance and saturate at 2**CNT_W-1 with no wrap; erroneous requests are still counted.

Reset
REQ-028 SHALL, while rst_n is low at a clk edge, clear S1 and S2 valid, out_word (all zeros), out_err (0) and dec_count (0).
REQ-029 SHALL drive in_ready = 1 in the first cycle after reset deasserts.
REQ-030 SHALL discard any in-flight words when reset is applied mid-operation, with no out_valid until a new acceptance.

Structure
REQ-031 SHALL place the mode encodings (MODE_ONEHOT, MODE_THERM, MODE_ONECOLD, MODE_RSVD) and a helper function computing the bank count from SEL_W and SUB_W in the shared package decoder_pkg.
REQ-032 SHALL build the S2 decode from 2**(SEL_W-SUB_W) instances of one sub-module, decoder_bank, a combinational SUB_W-to-2**SUB_W one-hot decoder with enable, driven by the S1 bank enable.
REQ-033 SHALL produce thermometer and one-cold modes in the top level from the bank outputs, and SHALL truncate bank outputs above OUT_W-1.

Verification
REQ-034 SHALL cover defaults with out_ready = 1 and in_sel = 0, 5, 15 in mode 00 -> out_word 0x0001, 0x0020, 0x8000, each 2 cycles after acceptance, out_err = 0.
REQ-035 SHALL cover in_sel = 9 in mode 01 -> out_word 0x03FF; in mode 10 -> out_word 0xFDFF.
REQ-036 SHALL cover OUT_W = 12 with in_sel = 13 in mode 00 -> out_word 0x000, out_err = 1; and mode 11 with in_sel = 2 -> out_word 0x000, out_err = 1.
REQ-037 SHALL cover back-to-back requests 1, 2, 3 with out_ready held low 4 cycles -> in_ready falls after 2 accepts, out_word holds 0x0002, then 0x0002, 0x0004, 0x0008 emerge in order once out_ready rises.
REQ-038 SHALL cover CNT_W = 3 with 10 accepts -> dec_count reads 7 and remains 7.
REQ-039 SHALL cover rst_n low for 1 cycle with 2 words in flight -> out_valid = 0, dec_count = 0, in_ready = 1 next cycle, and no stale word emerges.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared decode-mode encodings and sizing helper for the pipelined select decoder.
// Pure definitions: no latency, no flow control.
package decoder_pkg;

   typedef enum logic [1:0] {
      MODE_ONEHOT  = 2'b00,
      MODE_THERM   = 2'b01,
      MODE_ONECOLD = 2'b10,
      MODE_RSVD    = 2'b11
   } mode_e;

   // Number of sub-decoder banks addressed by the upper select bits.
   function automatic int bank_count(input int sel_w, input int sub_w);
      return 1 << (sel_w - sub_w);
   endfunction

endpackage

// File: rtl/decoder_bank.sv
// Combinational SUB_W-to-2**SUB_W one-hot decoder with enable; zero latency.
// No flow control: output follows inputs within the cycle.
module decoder_bank #(
   parameter int SUB_W = 3
) (
   input  logic                  en,
   input  logic [SUB_W-1:0]      sel,
   output logic [(1<<SUB_W)-1:0] dec
);

   always_comb begin
      dec = '0;
      if (en) begin
         dec[sel] = 1'b1;
      end
   end

endmodule

// File: rtl/decoder_pipe_param.sv
// Two-stage select decoder (one-hot/thermometer/one-cold), 2-cycle latency, 1 word/cycle.
// Valid/ready both sides; a stalled output holds its word and S1 fills before in_ready drops.
module decoder_pipe_param
   import decoder_pkg::*;
#(
   parameter int SEL_W = 4,
   parameter int SUB_W = 3,
   parameter int OUT_W = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SEL_W-1:0] in_sel,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_word,
   output logic             out_err,
   output logic [CNT_W-1:0] dec_count
);

   localparam int BANKS  = bank_count(SEL_W, SUB_W);
   localparam int ROWS   = 1 << SUB_W;
   localparam int FULL_W = BANKS * ROWS;
   localparam logic [SEL_W:0]   OUT_LIM = (SEL_W+1)'(OUT_W);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic [SEL_W-1:0] sel;
      mode_e            mode;
      logic [BANKS-1:0] bank_en;
   } s1_t;

   s1_t              s1_dat;
   s1_t              s1_nxt;
   logic             s1_vld;
   logic             s2_vld;
   logic             s1_adv;
   logic             accept;
   logic [FULL_W-1:0] onehot_full;
   logic [OUT_W-1:0] therm;
   logic [OUT_W-1:0] word_d;
   logic             err_d;
   logic             run;

   assign s1_adv    = !s2_vld || out_ready;
   assign in_ready  = !s1_vld || s1_adv;
   assign accept    = in_valid && in_ready;
   assign out_valid = s2_vld;

   always_comb begin
      s1_nxt         = '0;
      s1_nxt.sel     = in_sel;
      s1_nxt.mode    = mode_e'(in_mode);
      s1_nxt.bank_en[in_sel[SEL_W-1:SUB_W]] = 1'b1;
   end

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      decoder_bank #(
         .SUB_W (SUB_W)
      ) u_bank (
         .en  (s1_dat.bank_en[b]),
         .sel (s1_dat.sel[SUB_W-1:0]),
         .dec (onehot_full[b*ROWS +: ROWS])
      );
   end

   // Thermometer bit k is set when the selected position is at or above k.
   always_comb begin
      therm = '0;
      run   = 1'b0;
      for (int k = FULL_W-1; k >= 0; k--) begin
         run = run | onehot_full[k];
         if (k < OUT_W) begin
            therm[k] = run;
         end
      end
   end

   always_comb begin
      err_d  = ({1'b0, s1_dat.sel} >= OUT_LIM) || (s1_dat.mode == MODE_RSVD);
      word_d = '0;
      if (!err_d) begin
         case (s1_dat.mode)
            MODE_ONEHOT:  word_d = onehot_full[OUT_W-1:0];
            MODE_THERM:   word_d = therm;
            MODE_ONECOLD: word_d = ~onehot_full[OUT_W-1:0];
            default:      word_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_vld <= 1'b0;
         s1_dat <= '0;
      end else if (in_ready) begin
         s1_vld <= in_valid;
         if (in_valid) begin
            s1_dat <= s1_nxt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_vld   <= 1'b0;
         out_word <= '0;
         out_err  <= 1'b0;
      end else if (s1_adv) begin
         s2_vld <= s1_vld;
         if (s1_vld) begin
            out_word <= word_d;
            out_err  <= err_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dec_count <= '0;
      end else if (accept && (dec_count != CNT_MAX)) begin
         dec_count <= dec_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_decoder_pipe_param.sv
// Bench for decoder_pipe_param: a default instance and a narrow one (OUT_W=12, CNT_W=3)
// share stimulus; a queue-based latency model and literal cases check both.
module tb_decoder_pipe_param;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [3:0]  in_sel;
   logic [1:0]  in_mode;
   logic        out_ready;

   logic        in_ready_a, out_valid_a, out_err_a;
   logic [15:0] out_word_a;
   logic [15:0] dec_count_a;
   logic        in_ready_b, out_valid_b, out_err_b;
   logic [11:0] out_word_b;
   logic [2:0]  dec_count_b;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   decoder_pipe_param u_dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_a),
      .in_sel    (in_sel),
      .in_mode   (in_mode),
      .out_valid (out_valid_a),
      .out_ready (out_ready),
      .out_word  (out_word_a),
      .out_err   (out_err_a),
      .dec_count (dec_count_a)
   );

   decoder_pipe_param #(
      .SEL_W (4),
      .SUB_W (2),
      .OUT_W (12),
      .CNT_W (3)
   ) u_dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_b),
      .in_sel    (in_sel),
      .in_mode   (in_mode),
      .out_valid (out_valid_b),
      .out_ready (out_ready),
      .out_word  (out_word_b),
      .out_err   (out_err_b),
      .dec_count (dec_count_b)
   );

   typedef struct {
      logic [3:0] sel;
      logic [1:0] mode;
      int         acc;
   } req_t;

   req_t q[$];
   int   cyc   = 0;
   int   cnt_a = 0;
   int   cnt_b = 0;
   bit   m_ov, m_ir;

   // {err, word} straight from the decode rules, for an OUT_W of out_w.
   function automatic logic [16:0] ref_dec(input int sel, input int mode, input int out_w);
      logic [15:0] w;
      w = '0;
      if (sel >= out_w || mode == 3) return {1'b1, 16'h0000};
      for (int k = 0; k < out_w; k++) begin
         case (mode)
            0:       w[k] = (k == sel);
            1:       w[k] = (k <= sel);
            default: w[k] = (k != sel);
         endcase
      end
      return {1'b0, w};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: words in flight form a FIFO of depth 2; the oldest is visible two cycles after its acceptance.
   initial forever begin
      @(posedge clk);
      m_ov = (q.size() > 0) && (cyc >= q[0].acc + 2);
      m_ir = !(q.size() == 2 && !out_ready);
      if (!rst_n) begin
         q.delete();
         cnt_a = 0;
         cnt_b = 0;
      end else begin
         if (m_ov && out_ready) void'(q.pop_front());
         if (in_valid && m_ir) begin
            q.push_back('{in_sel, in_mode, cyc});
            if (cnt_a < 65535) cnt_a++;
            if (cnt_b < 7) cnt_b++;
         end
      end
      cyc++;
   end

   initial forever begin
      logic [16:0] ea, eb;
      bit          ov, ir;
      @(negedge clk);
      if (chk_en) begin
         ov = (q.size() > 0) && (cyc >= q[0].acc + 2);
         ir = !(q.size() == 2 && !out_ready);
         check("m_out_valid_a", 32'(out_valid_a), 32'(ov));
         check("m_out_valid_b", 32'(out_valid_b), 32'(ov));
         check("m_in_ready_a", 32'(in_ready_a), 32'(ir));
         check("m_in_ready_b", 32'(in_ready_b), 32'(ir));
         check("m_count_a", 32'(dec_count_a), 32'(cnt_a));
         check("m_count_b", 32'(dec_count_b), 32'(cnt_b));
         if (ov) begin
            ea = ref_dec(int'(q[0].sel), int'(q[0].mode), 16);
            eb = ref_dec(int'(q[0].sel), int'(q[0].mode), 12);
            check("m_word_a", 32'(out_word_a), 32'(ea[15:0]));
            check("m_err_a", 32'(out_err_a), 32'(ea[16]));
            check("m_word_b", 32'(out_word_b), 32'(eb[15:0]));
            check("m_err_b", 32'(out_err_b), 32'(eb[16]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Single request from an idle pipe with out_ready high; literal result two cycles later.
   task automatic directed(input logic [3:0] sel, input logic [1:0] mode,
                           input logic [31:0] lit_a, input logic [31:0] err_a,
                           input logic [31:0] lit_b, input logic [31:0] err_b);
      in_valid = 1'b1;
      in_sel   = sel;
      in_mode  = mode;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("d_early_vld", 32'(out_valid_a), 0);
      tick();
      @(negedge clk);
      check("d_vld_a", 32'(out_valid_a), 1);
      check("d_word_a", 32'(out_word_a), lit_a);
      check("d_err_a", 32'(out_err_a), err_a);
      check("d_word_b", 32'(out_word_b), lit_b);
      check("d_err_b", 32'(out_err_b), err_b);
      tick();
   endtask

   initial begin
      bit acc_prev;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sel    = '0;
      in_mode   = '0;
      out_ready = 1'b1;
      repeat (2) tick();
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_vld_a", 32'(out_valid_a), 0);
      check("rst_word_a", 32'(out_word_a), 0);
      check("rst_err_a", 32'(out_err_a), 0);
      check("rst_cnt_a", 32'(dec_count_a), 0);
      check("rst_vld_b", 32'(out_valid_b), 0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_rdy_a", 32'(in_ready_a), 1);
      tick();

      directed(4'd0,  2'b00, 32'h0001, 0, 32'h001, 0);
      directed(4'd5,  2'b00, 32'h0020, 0, 32'h020, 0);
      directed(4'd15, 2'b00, 32'h8000, 0, 32'h000, 1);
      directed(4'd9,  2'b01, 32'h03FF, 0, 32'h3FF, 0);
      directed(4'd9,  2'b10, 32'hFDFF, 0, 32'hDFF, 0);
      directed(4'd13, 2'b00, 32'h2000, 0, 32'h000, 1);
      directed(4'd2,  2'b11, 32'h0000, 1, 32'h000, 1);

      // Back-to-back 1,2,3 into a stalled output.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_mode   = 2'b00;
      in_sel    = 4'd1;
      tick();
      in_sel = 4'd2;
      tick();
      in_sel = 4'd3;
      @(negedge clk);
      check("bb_rdy_low", 32'(in_ready_a), 0);
      check("bb_hold0", 32'(out_word_a), 32'h0002);
      tick();
      tick();
      @(negedge clk);
      check("bb_hold1", 32'(out_word_a), 32'h0002);
      check("bb_hold_vld", 32'(out_valid_a), 1);
      tick();
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("bb_second", 32'(out_word_a), 32'h0004);
      tick();
      @(negedge clk);
      check("bb_third", 32'(out_word_a), 32'h0008);
      tick();
      @(negedge clk);
      check("bb_drained", 32'(out_valid_a), 0);
      tick();

      // Reset with two words in flight.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_sel    = 4'd4;
      tick();
      in_sel = 4'd6;
      tick();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("mr_vld_a", 32'(out_valid_a), 0);
      check("mr_vld_b", 32'(out_valid_b), 0);
      check("mr_cnt_a", 32'(dec_count_a), 0);
      check("mr_cnt_b", 32'(dec_count_b), 0);
      check("mr_rdy_a", 32'(in_ready_a), 1);
      tick();
      out_ready = 1'b1;
      repeat (4) tick();
      @(negedge clk);
      check("mr_no_stale", 32'(out_valid_a), 0);
      tick();

      // Ten accepts: narrow counter saturates at 7.
      in_valid = 1'b1;
      in_mode  = 2'b00;
      for (int i = 0; i < 10; i++) begin
         in_sel = 4'($urandom_range(0, 15));
         tick();
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("sat_cnt_a", 32'(dec_count_a), 10);
      check("sat_cnt_b", 32'(dec_count_b), 7);
      tick();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("sat_hold_b", 32'(dec_count_b), 7);
      check("sat_next_a", 32'(dec_count_a), 11);
      tick();

      // Random traffic with random stalls; requests held until accepted.
      acc_prev = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         if (acc_prev || !in_valid) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_sel   = 4'($urandom_range(0, 15));
            in_mode  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         end
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc_prev = in_valid && in_ready_a;
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (5) tick();
      @(negedge clk);
      check("end_empty", 32'(out_valid_a), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
